// File: rtl/fbuf_scanout.sv
// fbuf_scanout: raster-order framebuffer BRAM reader with hsync/vsync/de timing generation.
// Optional build macro SCANOUT_TEST_PATTERN_EN adds a test_pattern input (h^v pattern, BRAM idle).
module fbuf_scanout #(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned FBUF_DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter bit          SYNC_POL        = 1'b0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       enable,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic                       test_pattern,
`endif
  output logic                       fbuf_en_rd,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
  output logic                       vid_hsync,
  output logic                       vid_vsync,
  output logic                       vid_de,
  output logic [FBUF_DATA_WIDTH-1:0] vid_pixel,
  output logic                       frame_start,
  output logic                       busy
);

  localparam int unsigned AW       = FBUF_ADDR_WIDTH;
  localparam int unsigned DW       = FBUF_DATA_WIDTH;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW      = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int unsigned VCW      = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
  localparam int unsigned HS_BEG   = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG   = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_BEG + V_SYNC;
  localparam int unsigned PIX_LAST = H_ACTIVE * V_ACTIVE - 1;
  // Stage-0 flags travel SRW stages before the output registers.
  localparam int unsigned SRW      = RD_LATENCY + 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [HCW-1:0]   h_q, h_d;
  logic [VCW-1:0]   v_q, v_d;
  logic [AW-1:0]    addr_q, addr_d;

  logic             active_c, hs_c, vs_c, fs_c, rd_c, busy_d;
  logic [SRW-1:0]   act_sr_q, hs_sr_q, vs_sr_q, fs_sr_q, drain_q;
  logic [DW-1:0]    pixel_d;

  logic             en_rd_q, hsync_q, vsync_q, de_q, fs_q, busy_q;
  logic [AW-1:0]    addr_out_q;
  logic [DW-1:0]    pixel_q;

  // Next-state logic: raster counters advance only in RUN; enable checked on the last frame clock.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        h_d    = '0;
        v_d    = '0;
        addr_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (active_c) addr_d = (addr_q == AW'(PIX_LAST)) ? '0 : addr_q + AW'(1);
        if (h_q == HCW'(H_TOTAL - 1)) begin
          h_d = '0;
          if (v_q == VCW'(V_TOTAL - 1)) begin
            v_d    = '0;
            addr_d = '0;
            if (!enable) state_d = IDLE;
          end else begin
            v_d = v_q + VCW'(1);
          end
        end else begin
          h_d = h_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage-0 decode from the counters.
  always_comb begin
    active_c = (state_q == RUN) && (h_q < HCW'(H_ACTIVE)) && (v_q < VCW'(V_ACTIVE));
    hs_c     = (state_q == RUN) && (h_q >= HCW'(HS_BEG)) && (h_q < HCW'(HS_END));
    vs_c     = (state_q == RUN) && (v_q >= VCW'(VS_BEG)) && (v_q < VCW'(VS_END));
    fs_c     = (state_q == RUN) && (h_q == '0) && (v_q == '0);
`ifdef SCANOUT_TEST_PATTERN_EN
    rd_c     = active_c && !test_pattern;
`else
    rd_c     = active_c;
`endif
    busy_d   = (state_d == RUN) || (state_q == RUN) || (|drain_q);
  end

`ifdef SCANOUT_TEST_PATTERN_EN
  logic [SRW-1:0]         tp_sr_q;
  logic [SRW-1:0][DW-1:0] pix_sr_q;

  // Test-pattern select and value ride alongside the BRAM read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tp_sr_q  <= '0;
      pix_sr_q <= '0;
    end else begin
      tp_sr_q  <= {tp_sr_q[SRW-2:0], test_pattern};
      pix_sr_q <= {pix_sr_q[SRW-2:0], DW'(h_q[7:0] ^ v_q[7:0])};
    end
  end
`endif

  always_comb begin
    pixel_d = '0;
    if (act_sr_q[SRW-1]) begin
`ifdef SCANOUT_TEST_PATTERN_EN
      pixel_d = tp_sr_q[SRW-1] ? pix_sr_q[SRW-1] : fbuf_data;
`else
      pixel_d = fbuf_data;
`endif
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      h_q        <= '0;
      v_q        <= '0;
      addr_q     <= '0;
      act_sr_q   <= '0;
      hs_sr_q    <= '0;
      vs_sr_q    <= '0;
      fs_sr_q    <= '0;
      drain_q    <= '0;
      en_rd_q    <= 1'b0;
      addr_out_q <= '0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      de_q       <= 1'b0;
      pixel_q    <= '0;
      fs_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      addr_q     <= addr_d;
      act_sr_q   <= {act_sr_q[SRW-2:0], active_c};
      hs_sr_q    <= {hs_sr_q[SRW-2:0], hs_c};
      vs_sr_q    <= {vs_sr_q[SRW-2:0], vs_c};
      fs_sr_q    <= {fs_sr_q[SRW-2:0], fs_c};
      drain_q    <= {drain_q[SRW-2:0], (state_q == RUN)};
      en_rd_q    <= rd_c;
      addr_out_q <= addr_q;
      hsync_q    <= hs_sr_q[SRW-1] ? SYNC_POL : ~SYNC_POL;
      vsync_q    <= vs_sr_q[SRW-1] ? SYNC_POL : ~SYNC_POL;
      de_q       <= act_sr_q[SRW-1];
      pixel_q    <= pixel_d;
      fs_q       <= fs_sr_q[SRW-1];
      busy_q     <= busy_d;
    end
  end

  assign fbuf_en_rd  = en_rd_q;
  assign fbuf_addr   = addr_out_q;
  assign vid_hsync   = hsync_q;
  assign vid_vsync   = vsync_q;
  assign vid_de      = de_q;
  assign vid_pixel   = pixel_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fbuf_scanout.sv
// Testbench for fbuf_scanout: two instances (read latency 1 and 2) against a raster timing model.
module tb_fbuf_scanout;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       en_a, en_b;
  logic       rd_a, rd_b;
  logic [7:0] addr_a, addr_b, data_a, data_b;
  logic       hs_a, hs_b, vs_a, vs_b, de_a, de_b, fs_a, fs_b, busy_a, busy_b;
  logic [7:0] pix_a, pix_b;
`ifdef SCANOUT_TEST_PATTERN_EN
  logic       tp;
`endif

  int total = 0;
  int bad   = 0;
  bit sel;

  always #5 aclk = ~aclk;

  fbuf_scanout #(
    .FBUF_ADDR_WIDTH(8), .FBUF_DATA_WIDTH(8), .RD_LATENCY(1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut_a (
    .aclk(aclk), .aresetn(aresetn), .enable(en_a),
`ifdef SCANOUT_TEST_PATTERN_EN
    .test_pattern(tp),
`endif
    .fbuf_en_rd(rd_a), .fbuf_addr(addr_a), .fbuf_data(data_a),
    .vid_hsync(hs_a), .vid_vsync(vs_a), .vid_de(de_a), .vid_pixel(pix_a),
    .frame_start(fs_a), .busy(busy_a)
  );

  fbuf_scanout #(
    .FBUF_ADDR_WIDTH(8), .FBUF_DATA_WIDTH(8), .RD_LATENCY(2),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut_b (
    .aclk(aclk), .aresetn(aresetn), .enable(en_b),
`ifdef SCANOUT_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .fbuf_en_rd(rd_b), .fbuf_addr(addr_b), .fbuf_data(data_b),
    .vid_hsync(hs_b), .vid_vsync(vs_b), .vid_de(de_b), .vid_pixel(pix_b),
    .frame_start(fs_b), .busy(busy_b)
  );

  // BRAM models: data = addr + 8'h10 after one or two clocks.
  logic [7:0] bram_a_q, bram_b1_q, bram_b2_q;
  always_ff @(posedge aclk) begin
    if (rd_a) bram_a_q <= addr_a + 8'h10;
    if (rd_b) bram_b1_q <= addr_b + 8'h10;
    bram_b2_q <= bram_b1_q;
  end
  assign data_a = bram_a_q;
  assign data_b = bram_b2_q;

  logic       o_rd, o_hs, o_vs, o_de, o_fs, o_busy;
  logic [7:0] o_addr, o_pix;
  always_comb begin
    if (sel) begin
      o_rd = rd_b; o_addr = addr_b; o_hs = hs_b; o_vs = vs_b;
      o_de = de_b; o_pix = pix_b; o_fs = fs_b; o_busy = busy_b;
    end else begin
      o_rd = rd_a; o_addr = addr_a; o_hs = hs_a; o_vs = vs_a;
      o_de = de_a; o_pix = pix_a; o_fs = fs_a; o_busy = busy_a;
    end
  end

  task automatic set_en(input bit val);
    if (sel) en_b = val;
    else     en_a = val;
  endtask

  // Start a run on the selected instance, drive enable and check every output cycle.
  // k frames are scanned; enable is only meaningful on each frame's last clock.
  task automatic scan_frames(input bit s, input int k, input bit rnd, input bit tpm);
    int lat, p, q, h, v, p1, q1, h1, v1;
    bit valid, e_de, e_hs, e_vs, e_fs, e_busy, e_rd;
    logic [7:0] e_pix, e_addr;
    logic [12:0] obs, exp_v;
    sel = s;
    lat = s ? 4 : 3;
    @(negedge aclk);
    set_en(1'b1);
    @(negedge aclk);
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_rise dut=%0d got=%b exp=1", s, o_busy);
    end
    for (int j = 0; j < k * FR + lat + 3; j++) begin
      if (j > 0) @(negedge aclk);
      p     = j - lat;
      valid = (p >= 0) && (p < k * FR);
      q     = valid ? p % FR : 0;
      h     = q % HT;
      v     = q / HT;
      e_de  = valid && h < HA && v < VA;
      e_pix = !e_de ? 8'h00 : (tpm ? 8'(h ^ v) : 8'(16 + v * HA + h));
      e_hs  = !(valid && h >= HA + HF && h < HA + HF + HS);
      e_vs  = !(valid && v >= VA + VF && v < VA + VF + VS);
      e_fs  = valid && q == 0;
      e_busy = j < k * FR + lat;
      obs   = {o_de, o_hs, o_vs, o_fs, o_busy, o_pix};
      exp_v = {e_de, e_hs, e_vs, e_fs, e_busy, e_pix};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL scan dut=%0d j=%0d {de,hs,vs,fs,busy,pix} got=%h exp=%h", s, j, obs, exp_v);
      end
      p1   = j - 1;
      q1   = (p1 >= 0 && p1 < k * FR) ? p1 % FR : FR - 1;
      h1   = q1 % HT;
      v1   = q1 / HT;
      e_rd = !tpm && p1 >= 0 && p1 < k * FR && h1 < HA && v1 < VA;
      e_addr = 8'(v1 * HA + h1);
      total++;
      if (o_rd !== e_rd || (e_rd && o_addr !== e_addr)) begin
        bad++;
        $display("FAIL bram_rd dut=%0d j=%0d en/addr got=%b/%h exp=%b/%h", s, j, o_rd, o_addr, e_rd, e_addr);
      end
      if (j < k * FR) begin
        if (j % FR == FR - 1) set_en(j / FR < k - 1);
        else if (rnd)         set_en($urandom_range(0, 1) == 1);
        else                  set_en(j < (k - 1) * FR + HT + 2);
      end else begin
        set_en(1'b0);
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] ra, rb;
    aresetn = 1'b0;
    en_a = 1'b1;
    en_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      ra = {de_a, rd_a, busy_a, hs_a, vs_a, fs_a, pix_a};
      rb = {de_b, rd_b, busy_b, hs_b, vs_b, fs_b, pix_b};
      total++;
      if (ra !== 14'b00011000000000 || rb !== 14'b00011000000000) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h/%h exp=%h", i, ra, rb, 14'b00011000000000);
      end
    end
    en_a = 1'b0;
    en_b = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    total++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || de_a !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b/%b de=%b exp=0/0 0", busy_a, busy_b, de_a);
    end
  endtask

  task automatic test_first_frame_stop();
    scan_frames(1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    scan_frames(1'b0, 2, 1'b0, 1'b0);
    scan_frames(1'b0, int'($urandom_range(2, 3)), 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [14:0] obs;
    sel = 1'b0;
    @(negedge aclk);
    en_a = 1'b1;
    // stage 0 sits at (v=1,h=2) in the cycle after the 10th negedge past busy rising
    repeat (11) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    obs = {de_a, rd_a, busy_a, hs_a, vs_a, fs_a, pix_a, 1'b0};
    total++;
    if (obs !== 15'b000110000000000) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", obs, 15'b000110000000000);
    end
    en_a = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_busy got=%b exp=0", busy_a);
    end
    scan_frames(1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_latency2();
    scan_frames(1'b1, 1, 1'b0, 1'b0);
    scan_frames(1'b1, int'($urandom_range(1, 2)), 1'b1, 1'b0);
  endtask

`ifdef SCANOUT_TEST_PATTERN_EN
  task automatic test_pattern_mode();
    tp = 1'b1;
    scan_frames(1'b0, 1, 1'b0, 1'b1);
    tp = 1'b0;
  endtask
`endif

  initial begin
    aresetn = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    sel = 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
    tp = 1'b0;
`endif
    test_reset();
    test_first_frame_stop();
    test_back_to_back();
    test_async_reset();
    test_latency2();
`ifdef SCANOUT_TEST_PATTERN_EN
    test_pattern_mode();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
